// File: rtl/bitlink_pkg.sv
// bitlink_pkg -- shared constants and types for the bitlink host.
//   IDX_W      : width of the command bit index (byte = {idx, val})
//   CHAR_*     : ASCII codes used by the device frame stream
//   tx_state_t : TX scheduler states
package bitlink_pkg;

  localparam int         IDX_W     = 7;
  localparam logic [7:0] CHAR_ZERO = 8'd48;  // '0'
  localparam logic [7:0] CHAR_ONE  = 8'd49;  // '1'
  localparam logic [7:0] CHAR_END  = 8'd42;  // '*'

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } tx_state_t;

endpackage

// File: rtl/bitlink_frame_rx.sv
// bitlink_frame_rx -- assembles '0'/'1' ASCII frames terminated by '*'.
// Ports:
//   clk_48mhz, reset           : clock, synchronous active-high reset
//   frm_data/frm_valid/frm_ready : incoming byte stream (always ready out of reset)
//   rx_vec                     : last good frame, character k -> bit k
//   rx_valid/rx_err_len/rx_err_char : single-cycle status pulses
module bitlink_frame_rx
  import bitlink_pkg::*;
#(
  parameter int OL = 64
) (
  input  logic          clk_48mhz,
  input  logic          reset,
  input  logic [7:0]    frm_data,
  input  logic          frm_valid,
  output logic          frm_ready,
  output logic [OL-1:0] rx_vec,
  output logic          rx_valid,
  output logic          rx_err_len,
  output logic          rx_err_char
);

  localparam int CW = $clog2(OL + 1);
  localparam int AW = (OL > 1) ? $clog2(OL) : 1;

  logic [CW-1:0] r_count;
  logic [OL-1:0] r_asm;
  logic [OL-1:0] r_vec;
  // Length and character faults are tracked apart so that a frame whose
  // only problem was a bad character does not also report a length error.
  logic          r_bad_len;
  logic          r_bad_char;
  logic          r_valid;
  logic          r_err_len;
  logic          r_err_char;

  logic          w_acc;
  logic          w_bit_char;
  logic          w_end;
  logic          w_full;

  assign frm_ready  = ~reset;
  assign w_acc      = frm_valid & frm_ready;
  assign w_bit_char = (frm_data == CHAR_ZERO) || (frm_data == CHAR_ONE);
  assign w_end      = (frm_data == CHAR_END);
  assign w_full     = (r_count == CW'(OL));

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_count    <= '0;
      r_asm      <= '0;
      r_vec      <= '0;
      r_bad_len  <= 1'b0;
      r_bad_char <= 1'b0;
      r_valid    <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_char <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_char <= 1'b0;
      if (w_acc) begin
        if (w_bit_char) begin
          if (w_full) begin
            r_bad_len <= 1'b1;
          end else begin
            // count < OL here, so the low AW bits are a valid bit index
            r_asm[r_count[AW-1:0]] <= frm_data[0];
            r_count                <= r_count + 1'b1;
          end
        end else if (w_end) begin
          if (w_full && !r_bad_len && !r_bad_char) begin
            r_vec   <= r_asm;
            r_valid <= 1'b1;
          end else if (!w_full || r_bad_len) begin
            r_err_len <= 1'b1;
          end
          r_count    <= '0;
          r_bad_len  <= 1'b0;
          r_bad_char <= 1'b0;
        end else begin
          r_err_char <= 1'b1;
          r_bad_char <= 1'b1;
        end
      end
    end
  end

  assign rx_vec      = r_vec;
  assign rx_valid    = r_valid;
  assign rx_err_len  = r_err_len;
  assign rx_err_char = r_err_char;

endmodule

// File: rtl/bitlink_host.sv
// bitlink_host -- host side of a bit-vector link.
// TX: a loaded vector is scanned one bit per cycle; selected bits (changed
// since the last completed send, or all bits in full mode) go out as
// command bytes {idx[6:0], val}. RX: frames are handled by bitlink_frame_rx.
// Ports:
//   clk_48mhz, reset                  : clock, synchronous active-high reset
//   wr_vec/wr_req/wr_ready/wr_full    : vector load handshake (+ full-send flag)
//   cmd_data/cmd_valid/cmd_ready      : outgoing command byte stream
//   frm_data/frm_valid/frm_ready      : incoming ASCII frame stream
//   rx_vec, rx_valid, rx_err_len, rx_err_char : received vector and status
module bitlink_host
  import bitlink_pkg::*;
#(
  parameter int IL = 64,
  parameter int OL = 64
) (
  input  logic          clk_48mhz,
  input  logic          reset,
  input  logic [IL-1:0] wr_vec,
  input  logic          wr_req,
  output logic          wr_ready,
  input  logic          wr_full,
  output logic [7:0]    cmd_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  input  logic [7:0]    frm_data,
  input  logic          frm_valid,
  output logic          frm_ready,
  output logic [OL-1:0] rx_vec,
  output logic          rx_valid,
  output logic          rx_err_len,
  output logic          rx_err_char
);

  localparam int BW = (IL > 1) ? $clog2(IL) : 1;

  tx_state_t        r_state;
  tx_state_t        w_next;
  logic [IL-1:0]    r_shadow;
  logic [IL-1:0]    r_sent;
  logic             r_full;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_cmd_data;
  logic             r_cmd_valid;

  logic [BW-1:0]    w_bit;
  logic             w_load;
  logic             w_sel;
  logic             w_last;

  assign w_bit    = r_idx[BW-1:0];
  assign wr_ready = (r_state == IDLE) && !reset;

  always_comb begin
    w_load = (r_state == IDLE) && wr_req;
    w_sel  = r_full || (r_shadow[w_bit] != r_sent[w_bit]);
    w_last = (r_idx == IDX_W'(IL - 1));
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_next = SCAN;
      SCAN:    if (w_sel) w_next = SEND;
               else if (w_last) w_next = IDLE;
      SEND:    if (cmd_ready) w_next = w_last ? IDLE : SCAN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_shadow    <= '0;
      r_sent      <= '0;
      r_full      <= 1'b0;
      r_idx       <= '0;
      r_cmd_data  <= '0;
      r_cmd_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_shadow <= wr_vec;
            r_full   <= wr_full;
            r_idx    <= '0;
          end
        end
        SCAN: begin
          if (w_sel) begin
            r_cmd_data  <= {r_idx, r_shadow[w_bit]};
            r_cmd_valid <= 1'b1;
          end else if (w_last) begin
            r_sent <= r_shadow;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        SEND: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            // sent only advances when the whole scan finishes, so an aborted
            // send leaves the previous reference intact
            if (w_last) r_sent <= r_shadow;
            else        r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_data  = r_cmd_data;
  assign cmd_valid = r_cmd_valid;

  bitlink_frame_rx #(.OL(OL)) u_rx (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .frm_data    (frm_data),
    .frm_valid   (frm_valid),
    .frm_ready   (frm_ready),
    .rx_vec      (rx_vec),
    .rx_valid    (rx_valid),
    .rx_err_len  (rx_err_len),
    .rx_err_char (rx_err_char)
  );

endmodule

// File: tb/tb_bitlink_host.sv
module tb_bitlink_host;

  localparam int IL = 64;
  localparam int OL = 64;
  localparam logic [7:0] C0 = 8'd48;
  localparam logic [7:0] C1 = 8'd49;
  localparam logic [7:0] CE = 8'd42;
  localparam logic [7:0] CX = 8'd120;  // 'x'
  localparam int EV_VALID = 0;
  localparam int EV_ELEN  = 1;
  localparam int EV_ECHAR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [IL-1:0] wr_vec;
  logic          wr_req, wr_ready, wr_full;
  logic [7:0]    cmd_data;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    frm_data;
  logic          frm_valid, frm_ready;
  logic [OL-1:0] rx_vec;
  logic          rx_valid, rx_err_len, rx_err_char;

  typedef struct {
    int            kind;
    logic [OL-1:0] vec;
  } rx_ev_t;

  int            checks = 0;
  int            errors = 0;
  int            n_bytes = 0;
  int            n_valid = 0;
  logic [7:0]    exp_q[$];
  rx_ev_t        rx_q[$];
  logic [IL-1:0] m_sent;
  logic [7:0]    mon_b;
  rx_ev_t        mon_r;
  int            mon_kind;

  always #10 clk = ~clk;

  bitlink_host #(.IL(IL), .OL(OL)) dut (
    .clk_48mhz(clk), .reset(reset),
    .wr_vec(wr_vec), .wr_req(wr_req), .wr_ready(wr_ready), .wr_full(wr_full),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .frm_data(frm_data), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .rx_vec(rx_vec), .rx_valid(rx_valid), .rx_err_len(rx_err_len), .rx_err_char(rx_err_char)
  );

  // scoreboard: pop expected command bytes and RX events as the DUT produces them
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        checks++;
        n_bytes++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_byte: got unexpected 0x%02h, required no byte", cmd_data);
        end else begin
          mon_b = exp_q.pop_front();
          if (cmd_data !== mon_b) begin
            errors++;
            $display("FAIL cmd_byte: got 0x%02h, required 0x%02h", cmd_data, mon_b);
          end
        end
      end
      if (rx_valid === 1'b1 || rx_err_len === 1'b1 || rx_err_char === 1'b1) begin
        checks++;
        mon_kind = (rx_valid === 1'b1) ? EV_VALID : (rx_err_len === 1'b1) ? EV_ELEN : EV_ECHAR;
        if (rx_valid === 1'b1) n_valid++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_event: got unexpected kind %0d, required none", mon_kind);
        end else begin
          mon_r = rx_q.pop_front();
          if (mon_kind != mon_r.kind || (mon_kind == EV_VALID && rx_vec !== mon_r.vec)) begin
            errors++;
            $display("FAIL rx_event: got kind %0d vec %h, required kind %0d vec %h",
                     mon_kind, rx_vec, mon_r.kind, mon_r.vec);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: got wr_ready %b after %0d cycles, required 1", wr_ready, n);
    end
  endtask

  // load a vector; expected bytes go to the scoreboard from the bench's own model of sent
  task automatic do_load(input logic [IL-1:0] v, input logic f, output int nb);
    int n;
    logic [6:0] ii;
    wait_idle(n);
    nb = 0;
    for (int i = 0; i < IL; i++) begin
      if (f || v[i] !== m_sent[i]) begin
        ii = 7'(i);
        exp_q.push_back({ii, v[i]});
        nb++;
      end
    end
    wr_vec = v; wr_full = f; wr_req = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0; wr_vec = {$urandom, $urandom}; wr_full = $urandom_range(0, 1);
    m_sent = v;
  endtask

  task automatic wait_cmd_valid();
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_cmd_valid: got %b, required 1", cmd_valid);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    frm_valid = 1'b1; frm_data = c;
    @(posedge clk); #1;
  endtask

  task automatic idle_rx(input int k);
    frm_valid = 1'b0; frm_data = 8'h00;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_req = 1'b0; wr_vec = '0; wr_full = 1'b0; cmd_ready = 1'b1;
    frm_valid = 1'b0; frm_data = 8'h00; m_sent = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b, required 0", wr_ready); end
    checks++; if (frm_ready !== 1'b0) begin errors++; $display("FAIL reset_frm_ready: got %b, required 0", frm_ready); end
    checks++; if (cmd_valid !== 1'b0 || cmd_data !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %b/%h, required 0/00", cmd_valid, cmd_data); end
    checks++; if (rx_vec !== '0) begin errors++; $display("FAIL reset_rx_vec: got %h, required 0", rx_vec); end
    checks++; if ({rx_valid, rx_err_len, rx_err_char} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b, required 000", {rx_valid, rx_err_len, rx_err_char}); end
    reset = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1 || frm_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b%b, required 11", wr_ready, frm_ready); end
  endtask

  // bits 0 and 2 set against sent=0 -> bytes 0x01, 0x05
  task automatic test_diff_load();
    int nb, n, b0;
    cmd_ready = 1'b1; b0 = n_bytes;
    do_load(64'h5, 1'b0, nb);
    wait_idle(n);
    checks++; if (n != 66) begin errors++; $display("FAIL diff_cycles: got %0d, required 66", n); end
    checks++; if (n_bytes - b0 != 2 || exp_q.size() != 0) begin errors++; $display("FAIL diff_bytes: got %0d left %0d, required 2 left 0", n_bytes - b0, exp_q.size()); end
  endtask

  task automatic test_single_and_full();
    int nb, n, b0;
    b0 = n_bytes;
    do_load(64'h4, 1'b0, nb);
    wait_idle(n);
    checks++; if (n != 65 || n_bytes - b0 != 1) begin errors++; $display("FAIL single_change: got %0d cyc %0d bytes, required 65 cyc 1 byte", n, n_bytes - b0); end
    b0 = n_bytes;
    do_load(64'h4, 1'b0, nb);
    wait_idle(n);
    checks++; if (n != 64 || n_bytes - b0 != 0) begin errors++; $display("FAIL no_change: got %0d cyc %0d bytes, required 64 cyc 0 bytes", n, n_bytes - b0); end
    b0 = n_bytes;
    do_load(64'h4, 1'b1, nb);
    wait_idle(n);
    checks++; if (n != 128 || n_bytes - b0 != 64 || exp_q.size() != 0) begin errors++; $display("FAIL full_send: got %0d cyc %0d bytes, required 128 cyc 64 bytes", n, n_bytes - b0); end
  endtask

  task automatic test_ignore_busy();
    int nb, n, b0;
    b0 = n_bytes;
    do_load({$urandom, $urandom}, 1'b0, nb);
    wr_req = 1'b1;
    repeat (20) begin wr_vec = {$urandom, $urandom}; wr_full = 1'b1; @(posedge clk); #1; end
    wr_req = 1'b0;
    wait_idle(n);
    checks++; if (n_bytes - b0 != nb || exp_q.size() != 0) begin errors++; $display("FAIL ignore_busy: got %0d bytes, required %0d", n_bytes - b0, nb); end
  endtask

  task automatic test_stall();
    int nb, n, b0;
    logic [IL-1:0] v;
    logic [7:0] eb;
    v = m_sent ^ (64'h1 << 9);
    eb = {7'd9, v[9]};
    b0 = n_bytes; cmd_ready = 1'b0;
    do_load(v, 1'b0, nb);
    wait_cmd_valid();
    repeat (5) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_data !== eb) begin errors++; $display("FAIL stall_hold: got %b/%h, required 1/%h", cmd_valid, cmd_data, eb); end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1;
    wait_idle(n);
    checks++; if (n_bytes - b0 != 1 || exp_q.size() != 0) begin errors++; $display("FAIL stall_bytes: got %0d, required 1", n_bytes - b0); end
  endtask

  task automatic test_reset_mid();
    int nb, n;
    cmd_ready = 1'b0;
    do_load(64'hFF00, 1'b1, nb);
    wait_cmd_valid();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b, required 0", cmd_valid); end
    exp_q.delete(); m_sent = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b, required 1", wr_ready); end
    cmd_ready = 1'b1;
    do_load(64'h5, 1'b0, nb);
    wait_idle(n);
    checks++; if (n != 66 || exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_resend: got %0d cyc, required 66", n); end
  endtask

  task automatic send_frame(input logic [OL-1:0] v);
    for (int k = 0; k < OL; k++) send_char(v[k] ? C1 : C0);
  endtask

  task automatic test_rx_good();
    int v0 = n_valid;
    logic [OL-1:0] ev = {32{2'b01}};
    for (int k = 0; k < OL; k++) send_char((k % 2 == 0) ? C1 : C0);
    rx_q.push_back('{EV_VALID, ev});
    send_char(CE);
    idle_rx(3);
    checks++; if (rx_vec !== ev || n_valid - v0 != 1 || rx_q.size() != 0) begin errors++; $display("FAIL rx_good: got %h (%0d valid), required %h (1 valid)", rx_vec, n_valid - v0, ev); end
  endtask

  task automatic test_rx_errors();
    int v0 = n_valid;
    logic [OL-1:0] ev = {32{2'b01}};
    repeat (3) send_char(C1);
    rx_q.push_back('{EV_ELEN, '0});
    send_char(CE);
    idle_rx(3);
    checks++; if (rx_vec !== ev || rx_q.size() != 0) begin errors++; $display("FAIL rx_short: got %h, required %h", rx_vec, ev); end
    repeat (OL + 1) send_char(C0);
    rx_q.push_back('{EV_ELEN, '0});
    send_char(CE);
    idle_rx(3);
    checks++; if (rx_vec !== ev || rx_q.size() != 0) begin errors++; $display("FAIL rx_long: got %h, required %h", rx_vec, ev); end
    repeat (30) send_char(C0);
    rx_q.push_back('{EV_ECHAR, '0});
    send_char(CX);
    repeat (OL - 30) send_char(C1);
    send_char(CE);
    idle_rx(3);
    checks++; if (rx_vec !== ev || n_valid != v0 || rx_q.size() != 0) begin errors++; $display("FAIL rx_badchar: got %h (%0d valid), required %h (0 valid)", rx_vec, n_valid - v0, ev); end
  endtask

  // good frame right after the faulty ones: bad state must be cleared by '*'
  task automatic test_rx_random();
    logic [OL-1:0] v = {$urandom, $urandom};
    send_frame(v);
    rx_q.push_back('{EV_VALID, v});
    send_char(CE);
    idle_rx(3);
    checks++; if (rx_vec !== v || rx_q.size() != 0) begin errors++; $display("FAIL rx_random: got %h, required %h", rx_vec, v); end
  endtask

  task automatic test_concurrent();
    int nb, n, b0;
    logic [OL-1:0] v = {$urandom, $urandom};
    b0 = n_bytes;
    fork
      begin
        do_load({$urandom, $urandom}, 1'b1, nb);
        wait_idle(n);
      end
      begin
        send_frame(v);
        rx_q.push_back('{EV_VALID, v});
        send_char(CE);
        idle_rx(3);
      end
    join
    idle_rx(2);
    checks++; if (n_bytes - b0 != 64 || exp_q.size() != 0) begin errors++; $display("FAIL conc_tx: got %0d bytes, required 64", n_bytes - b0); end
    checks++; if (rx_vec !== v || rx_q.size() != 0) begin errors++; $display("FAIL conc_rx: got %h, required %h", rx_vec, v); end
  endtask

  initial begin
    test_reset();
    test_diff_load();
    test_single_and_full();
    test_ignore_busy();
    test_stall();
    test_reset_mid();
    test_rx_good();
    test_rx_errors();
    test_rx_random();
    test_concurrent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
